// File: rtl/des_pkg.sv
// Shared constants, permutation tables and rotate helpers for the DES key schedule.
// PC1/PC2 entries use the standard 1-based DES bit numbering (bit 1 = MSB).
package des_pkg;

    localparam int HALF_W = 28;
    localparam int CD_W   = 56;
    localparam int RK_W   = 48;
    localparam int KEY_W  = 56;
    localparam int ROUNDS = 16;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } sched_state_e;

    // Positions refer to the original 64-bit key, parity bits included.
    localparam int PC1 [CD_W] = '{
        57, 49, 41, 33, 25, 17,  9,
         1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27,
        19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,
         7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29,
        21, 13,  5, 28, 20, 12,  4
    };

    localparam int PC2 [RK_W] = '{
        14, 17, 11, 24,  1,  5,
         3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8,
        16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55,
        30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53,
        46, 42, 50, 36, 29, 32
    };

    localparam logic [1:0] SHIFT [ROUNDS] = '{
        2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
        2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1
    };

    // Map an original key position (1..64, never a multiple of 8) onto the
    // bit index of the parity-stripped 56-bit input vector.
    function automatic int stripped_bit(input int pos);
        return KEY_W - (pos - (pos - 1) / 8);
    endfunction

    function automatic logic [1:0] shift_amt(input logic [4:0] round);
        if (round >= 5'd1 && round <= 5'd16) begin
            return SHIFT[4'(round - 5'd1)];
        end
        return 2'd1;
    endfunction

    function automatic logic [HALF_W-1:0] rotl_half(input logic [HALF_W-1:0] x,
                                                    input logic [1:0] n);
        return (n == 2'd2) ? {x[HALF_W-3:0], x[HALF_W-1:HALF_W-2]}
                           : {x[HALF_W-2:0], x[HALF_W-1]};
    endfunction

    function automatic logic [HALF_W-1:0] rotr_half(input logic [HALF_W-1:0] x,
                                                    input logic [1:0] n);
        return (n == 2'd2) ? {x[1:0], x[HALF_W-1:2]}
                           : {x[0], x[HALF_W-1:1]};
    endfunction

    function automatic logic [CD_W-1:0] rotl_cd(input logic [CD_W-1:0] cd,
                                                input logic [1:0] n);
        return {rotl_half(cd[CD_W-1:HALF_W], n), rotl_half(cd[HALF_W-1:0], n)};
    endfunction

    function automatic logic [CD_W-1:0] rotr_cd(input logic [CD_W-1:0] cd,
                                                input logic [1:0] n);
        return {rotr_half(cd[CD_W-1:HALF_W], n), rotr_half(cd[HALF_W-1:0], n)};
    endfunction

endpackage

// File: rtl/des_pc2.sv
// Combinational PC-2 compression permutation: 56-bit CD register -> 48-bit round key.
// Eight CD positions are dropped by PC-2 by definition.
module des_pc2
    import des_pkg::*;
(
    input  logic [CD_W-1:0] cd_in,
    output logic [RK_W-1:0] key_out
);

    logic unused_cd;

    for (genvar i = 0; i < RK_W; i++) begin : g_bit
        assign key_out[RK_W-1-i] = cd_in[CD_W - PC2[i]];
    end

    assign unused_cd = ^cd_in;

endmodule

// File: rtl/des_key_schedule.sv
// DES round-key generator: loads a parity-stripped key and streams K1..K16 (or K16..K1)
// over a valid/ready handshake. Define DES_KEY_SCHED_ABORT_EN to add the abort_in port.
module des_key_schedule
    import des_pkg::*;
#(
    parameter int IDX_W = 4
) (
    input  logic             clk_in,
    input  logic             rst_n_in,
    input  logic [KEY_W-1:0] sub_key_in,
    input  logic             sub_key_in_valid,
    input  logic             check_error_in,
    input  logic             mode_in,
`ifdef DES_KEY_SCHED_ABORT_EN
    input  logic             abort_in,
`endif
    output logic             sub_key_in_ready,
    output logic [RK_W-1:0]  round_key_out,
    output logic [IDX_W-1:0] round_idx_out,
    output logic             round_key_valid,
    input  logic             round_key_ready,
    output logic             sched_done,
    output logic             sched_err
);

    sched_state_e     state_q, state_d;
    logic [CD_W-1:0]  cd_q, cd_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             mode_q, mode_d;
    logic             done_q, done_d;
    logic             err_q, err_d;

    logic [CD_W-1:0]  pc1_key;
    logic             key_offer;
    logic             handshake;
    logic             last_idx;
    logic             abort_req;
    logic [4:0]       enc_round;
    logic [4:0]       dec_round;

    for (genvar i = 0; i < CD_W; i++) begin : g_pc1
        assign pc1_key[CD_W-1-i] = sub_key_in[stripped_bit(PC1[i])];
    end

`ifdef DES_KEY_SCHED_ABORT_EN
    assign abort_req = abort_in;
`else
    assign abort_req = 1'b0;
`endif

    assign key_offer = (state_q == ST_IDLE) && sub_key_in_valid;
    assign handshake = (state_q == ST_RUN) && round_key_ready;
    assign last_idx  = (idx_q == IDX_W'(ROUNDS - 1));
    // Encrypt moves to round idx+2; decrypt undoes the shift of current round 16-idx.
    assign enc_round = 5'(idx_q) + 5'd2;
    assign dec_round = 5'd16 - 5'(idx_q);

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q <= ST_IDLE;
            cd_q    <= '0;
            idx_q   <= '0;
            mode_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cd_q    <= cd_d;
            idx_q   <= idx_d;
            mode_q  <= mode_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (key_offer && !check_error_in) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (abort_req || (handshake && last_idx)) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        cd_d   = cd_q;
        idx_d  = idx_q;
        mode_d = mode_q;
        done_d = 1'b0;
        err_d  = 1'b0;
        if (key_offer) begin
            if (check_error_in) begin
                err_d = 1'b1;
            end else begin
                mode_d = mode_in;
                idx_d  = '0;
                // Decrypt starts from C16D16, which equals C0D0 after 28 total shifts.
                cd_d   = mode_in ? pc1_key : rotl_cd(pc1_key, 2'd1);
            end
        end else if (handshake && !abort_req) begin
            if (last_idx) begin
                done_d = 1'b1;
            end else begin
                idx_d = idx_q + IDX_W'(1);
                cd_d  = mode_q ? rotr_cd(cd_q, shift_amt(dec_round))
                               : rotl_cd(cd_q, shift_amt(enc_round));
            end
        end
    end

    always_comb begin
        sub_key_in_ready = (state_q == ST_IDLE);
        round_key_valid  = (state_q == ST_RUN);
        round_idx_out    = idx_q;
        sched_done       = done_q;
        sched_err        = err_q;
    end

    des_pc2 u_pc2 (
        .cd_in   (cd_q),
        .key_out (round_key_out)
    );

endmodule
